// File: rtl/edge_det_array.sv
// Multi-channel input conditioner: per-channel synchroniser, debounce filter,
// selectable edge pulse and sticky event flag, plus a global any-event summary.

module edge_det_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_COUNT    = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       pulse,
    output logic       event_flag,
    output logic       flag_next
);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   expire;
    logic                   pulse_next;

    assign s = sync[SYNC_STAGES-1];

    // The filtered level flips on the cycle the counter has seen DB_COUNT
    // consecutive differing samples; the pulse is decided on that same edge.
    assign expire     = (s != level) && (cnt == CNT_W'(DB_COUNT - 1));
    assign pulse_next = expire & ((s & mode[0]) | (~s & mode[1]));
    assign flag_next  = (event_flag & ~clr) | pulse_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            cnt        <= '0;
            level      <= 1'b0;
            pulse      <= 1'b0;
            event_flag <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (s == level) begin
                cnt <= '0;
            end else if (expire) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            pulse      <= pulse_next;
            event_flag <= flag_next;
        end
    end

endmodule

module edge_det_array #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_COUNT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   event_flag,
    output logic                  any_event
);

    localparam int CNT_W = $clog2(DB_COUNT + 1);

    logic [CHANNELS-1:0] flag_next;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        edge_det_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_COUNT    (DB_COUNT),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .din        (din[g]),
            .mode       (mode[2*g +: 2]),
            .clr        (clr[g]),
            .level      (level[g]),
            .pulse      (pulse[g]),
            .event_flag (event_flag[g]),
            .flag_next  (flag_next[g])
        );
    end

    // Built from next-state flags so the summary lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) any_event <= 1'b0;
        else     any_event <= |flag_next;
    end

endmodule
